// File: rtl/prbs_tx_sequencer.sv
// Run/stop and burst sequencer for the PRBS9 transmit source: issues one symbol
// strobe every OS_RATIO clocks while running and counts the strobes issued.
module prbs_tx_sequencer #(
  parameter int OS_RATIO = 4,
  parameter int LEN_W    = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_mode,
  input  logic [LEN_W-1:0] i_burst_len,
  output logic             o_prbs_enb,
  output logic             o_enb_tx,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_bit_count
);
  localparam int PH_W = (OS_RATIO > 1) ? $clog2(OS_RATIO) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OS_RATIO - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [PH_W-1:0]  phase;
  logic [LEN_W-1:0] remaining;
  logic             burst;
  logic             strobe, last, arm;

  assign strobe = (state == S_RUN) && (phase == PH_LAST);
  assign last   = burst && strobe && (remaining == LEN_W'(1));
  // Arming is shared by IDLE and DONE; DONE re-arms without touching the generator.
  assign arm    = (state != S_RUN) && !i_stop && i_start;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    o_prbs_enb = 1'b0;
    o_enb_tx   = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        o_done = (state == S_DONE);
        if (i_stop)       state_nxt = S_IDLE;
        else if (i_start) state_nxt = (i_mode && (i_burst_len == '0)) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        o_prbs_enb = strobe;
        o_enb_tx   = 1'b1;
        o_busy     = 1'b1;
        if (i_stop)    state_nxt = S_IDLE;
        else if (last) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      phase       <= '0;
      remaining   <= '0;
      burst       <= 1'b0;
      o_bit_count <= '0;
    end else if (arm) begin
      phase       <= '0;
      remaining   <= i_burst_len;
      burst       <= i_mode;
      o_bit_count <= '0;
    end else if (state == S_RUN) begin
      phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
      if (strobe) begin
        if (o_bit_count != '1)                o_bit_count <= o_bit_count + 1'b1;
        if (burst && (remaining != '0))       remaining   <= remaining - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_prbs_tx_sequencer.sv
// Bench for prbs_tx_sequencer: directed table, hand sequences and random stimulus
// against a run-cycle-index reference model; a CNT_W=4 copy checks saturation.
module tb_prbs_tx_sequencer;
  localparam int OS = 4;

  logic        clock = 1'b0;
  logic        i_reset;
  logic        i_start, i_stop, i_mode;
  logic [15:0] i_burst_len;
  logic        o_prbs_enb, o_enb_tx, o_busy, o_done;
  logic [31:0] o_bit_count;
  logic        s_prbs_enb, s_enb_tx, s_busy, s_done;
  logic [3:0]  s_bit_count;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  prbs_tx_sequencer #(.OS_RATIO(OS), .LEN_W(16), .CNT_W(32)) dut (
    .clock(clock), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop),
    .i_mode(i_mode), .i_burst_len(i_burst_len), .o_prbs_enb(o_prbs_enb),
    .o_enb_tx(o_enb_tx), .o_busy(o_busy), .o_done(o_done), .o_bit_count(o_bit_count));

  prbs_tx_sequencer #(.OS_RATIO(OS), .LEN_W(16), .CNT_W(4)) dut4 (
    .clock(clock), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop),
    .i_mode(i_mode), .i_burst_len(i_burst_len), .o_prbs_enb(s_prbs_enb),
    .o_enb_tx(s_enb_tx), .o_busy(s_busy), .o_done(s_done), .o_bit_count(s_bit_count));

  // Reference model: state as 0=idle 1=run 2=done, run cycles elapsed, strobes left.
  int      m_state, m_k, m_left;
  bit      m_burst;
  longint  m_cnt;

  function automatic bit m_strobe();
    return (m_state == 1) && ((m_k % OS) == OS - 1);
  endfunction

  function automatic longint sat(longint v, int w);
    longint mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic m_reset();
    m_state = 0; m_k = 0; m_left = 0; m_burst = 0; m_cnt = 0;
  endtask

  task automatic m_step(bit st, bit sp, bit md, int ln);
    bit s = m_strobe();
    if (m_state == 1) begin
      if (s) begin
        m_cnt++;
        if (m_burst) m_left--;
      end
      if (sp)                        m_state = 0;
      else if (m_burst && s && m_left == 0) m_state = 2;
      else                           m_k++;
    end else if (sp) begin
      m_state = 0;
    end else if (st) begin
      m_cnt = 0; m_k = 0; m_burst = md; m_left = ln;
      m_state = (md && ln == 0) ? 2 : 1;
    end
  endtask

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    check("flags", {o_prbs_enb, o_enb_tx, o_busy, o_done},
          {m_strobe(), m_state == 1, m_state == 1, m_state == 2});
    check("bit_count", o_bit_count, sat(m_cnt, 32));
    check("bit_count4", s_bit_count, sat(m_cnt, 4));
  endtask

  // Drive at negedge, clock once, check at the following negedge.
  task automatic step(bit st, bit sp, bit md, int ln);
    i_start = st; i_stop = sp; i_mode = md; i_burst_len = 16'(ln);
    @(posedge clock);
    m_step(st, sp, md, ln);
    @(negedge clock);
    check_model();
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    m_reset();
    repeat (2) @(negedge clock);
    i_reset = 1'b1;
    @(negedge clock);
  endtask

  typedef struct {
    bit st, sp, md; int ln;
    bit e_stb, e_enb, e_busy, e_done; int e_cnt;
  } vec_t;

  initial begin
    vec_t tbl[$];
    int   n, first_done;
    tbl.push_back('{1,0,1,0, 0,0,0,1,0});  // len=0 burst -> DONE, no strobes
    tbl.push_back('{1,1,0,0, 0,0,0,0,0});  // stop wins in DONE
    tbl.push_back('{1,1,0,0, 0,0,0,0,0});  // start+stop in IDLE stays IDLE
    tbl.push_back('{1,0,0,0, 0,1,1,0,0});  // continuous start, RUN cycle 0
    tbl.push_back('{0,0,1,0, 0,1,1,0,0});
    tbl.push_back('{1,0,1,3, 0,1,1,0,0});  // start ignored in RUN
    tbl.push_back('{0,0,0,0, 1,1,1,0,0});  // RUN cycle 3 strobe
    tbl.push_back('{0,0,0,0, 0,1,1,0,1});
    tbl.push_back('{0,0,0,0, 0,1,1,0,1});
    tbl.push_back('{0,0,0,0, 0,1,1,0,1});
    tbl.push_back('{0,0,0,0, 1,1,1,0,1});  // RUN cycle 7 strobe
    tbl.push_back('{0,1,0,0, 0,0,0,0,2});  // stop in strobe cycle: counted
    tbl.push_back('{0,0,0,0, 0,0,0,0,2});

    i_reset = 1'b0; i_start = 0; i_stop = 0; i_mode = 0; i_burst_len = '0;
    m_reset();
    // Reset held while start toggles
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      i_start = ~i_start;
      #1 check("reset_hold", {o_prbs_enb, o_enb_tx, o_busy, o_done, o_bit_count}, 0);
    end
    i_start = 0;
    @(negedge clock);
    i_reset = 1'b1;
    @(negedge clock);
    check_model();
    step(0, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].st, tbl[i].sp, tbl[i].md, tbl[i].ln);
      check($sformatf("tbl%0d_flags", i), {o_prbs_enb, o_enb_tx, o_busy, o_done},
            {tbl[i].e_stb, tbl[i].e_enb, tbl[i].e_busy, tbl[i].e_done});
      check($sformatf("tbl%0d_cnt", i), o_bit_count, tbl[i].e_cnt);
    end

    // Continuous: 40 RUN cycles, strobes only at cycles 3,7,..,39
    step(1, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_prbs_enb) begin
        n++;
        check("strobe_pos", i % OS, OS - 1);
      end
      step(0, 0, 0, 0);
    end
    step(0, 1, 0, 0);
    check("cont_strobes", n, 10);
    check("cont_count", o_bit_count, 10);

    // Burst of 5: busy exactly 20 clocks, then DONE with tx disabled
    step(1, 0, 1, 5);
    n = 0; first_done = -1;
    for (int i = 0; i < 26; i++) begin
      if (o_busy) n++;
      if (o_done && first_done < 0) first_done = i;
      step(0, 0, 1, 9);
    end
    check("burst_busy", n, 20);
    check("burst_done_at", first_done, 20);
    check("burst_count", o_bit_count, 5);
    check("burst_enb_tx", o_enb_tx, 0);
    step(1, 0, 1, 2);                       // re-arm from DONE
    repeat (10) step(0, 0, 0, 0);
    check("rearm_count", o_bit_count, 2);

    // Async reset mid-burst at RUN cycle 10
    step(1, 0, 1, 8);
    repeat (10) step(0, 0, 0, 0);
    #2 i_reset = 1'b0;
    m_reset();
    #1 check("async_reset", {o_prbs_enb, o_enb_tx, o_busy, o_done, o_bit_count}, 0);
    @(negedge clock);
    i_reset = 1'b1;
    step(0, 0, 0, 0);

    // Random stimulus against the model
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0,
           1'($urandom), int'($urandom_range(0, 6)));

    // Saturation on the 4-bit counter copy
    do_reset();
    step(1, 0, 0, 0);
    repeat (85) step(0, 0, 0, 0);
    check("sat4_count", s_bit_count, 15);
    check("wide_count", o_bit_count, 21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
